// File: rtl/edge_pulse_generator_if.sv
// Trigger/level bundle between a pulse requester and edge_pulse_generator.
// The requester drives trigger; the generator drives the rest.
interface edge_pulse_generator_if #(
  parameter int PEND_W = 3
);
  logic              trigger;
  logic              data_out;
  logic              busy;
  logic              dropped;
  logic [PEND_W-1:0] pend_count;

  modport master (
    output trigger,
    input  data_out,
    input  busy,
    input  dropped,
    input  pend_count
  );

  modport slave (
    input  trigger,
    output data_out,
    output busy,
    output dropped,
    output pend_count
  );
endinterface

// File: rtl/edge_pulse_generator.sv
// Turns single-cycle triggers into fixed-width high pulses with a low gap.
// Define EDGE_PULSE_QUEUE_EN to queue triggers that arrive mid-pulse.
module edge_pulse_generator #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  edge_pulse_generator_if.slave  pg
);

  localparam int MAXC =
    (HIGH_CYCLES > LOW_CYCLES) ?
    HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W =
    (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] HI_LOAD =
    CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LO_LOAD =
    CNT_W'(LOW_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic              data_q;
  logic              drop_q;
  logic [PEND_W-1:0] pend_q;

  logic is_idle;
  logic is_high;
  logic is_gap;
  logic cnt_zero;
  logic last_gap;
  logic slot;
  logic pend_any;

  assign is_idle  = (state == IDLE);
  assign is_high  = (state == HIGH);
  assign is_gap   = (state == GAP);
  assign cnt_zero = (cnt == '0);
  assign last_gap = is_gap && cnt_zero;
  assign slot     = is_idle || last_gap;
  assign pend_any = (pend_q != '0);

  // State, cycle counter and registered level output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      data_q <= (state_nx == HIGH);
    end
  end

  // Next state: restart from the last gap cycle if work is waiting.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (1'b1)
      is_idle: begin
        if (pg.trigger) begin
          state_nx = HIGH;
          cnt_nx   = HI_LOAD;
        end
      end
      is_high: begin
        if (cnt_zero) begin
          state_nx = GAP;
          cnt_nx   = LO_LOAD;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      is_gap: begin
        if (!cnt_zero) begin
          cnt_nx = cnt - CNT_W'(1);
        end else if (pg.trigger || pend_any) begin
          state_nx = HIGH;
          cnt_nx   = HI_LOAD;
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

`ifdef EDGE_PULSE_QUEUE_EN
  logic pend_full;
  assign pend_full = &pend_q;

  // Queue late triggers; a restart with no new trigger pops one.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= '0;
      drop_q <= 1'b0;
    end else if (pg.trigger && !slot) begin
      if (pend_full) drop_q <= 1'b1;
      else pend_q <= pend_q + PEND_W'(1);
    end else if (last_gap && !pg.trigger
                 && pend_any) begin
      pend_q <= pend_q - PEND_W'(1);
    end
  end
`else
  assign pend_q = '0;

  // Without a queue, a late trigger is lost.
  always_ff @(posedge clock) begin
    if (reset) drop_q <= 1'b0;
    else if (pg.trigger && !slot)
      drop_q <= 1'b1;
  end
`endif

  // Outputs: busy decodes the state register.
  always_comb begin
    pg.data_out   = data_q;
    pg.busy       = !is_idle;
    pg.dropped    = drop_q;
    pg.pend_count = pend_q;
  end

endmodule

// File: tb/tb_edge_pulse_generator.sv
// Directed bench for edge_pulse_generator.
// Queue tests run when EDGE_PULSE_QUEUE_EN is defined.
module tb_edge_pulse_generator;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  edge_pulse_generator_if #(.PEND_W(3)) pg ();

  edge_pulse_generator #(
    .HIGH_CYCLES(4),
    .LOW_CYCLES (2),
    .PEND_W     (3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pg   (pg.slave)
  );

  always #5 clock = ~clock;

  logic prev_q = 1'b0;
  int   cyc    = 0;
  int   rise_n = 0;
  int   rise_cyc [64];

  // Same-clock positive-edge detector with a rise log.
  always @(posedge clock) begin
    prev_q <= pg.data_out;
    cyc    <= cyc + 1;
    if (pg.data_out && !prev_q) begin
      if (rise_n < 64) rise_cyc[rise_n] <= cyc;
      rise_n <= rise_n + 1;
    end
  end

  task automatic step(input logic t);
    pg.trigger = t;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic chk(input string nm,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, got, exp);
    end
  endtask

  task automatic test_reset();
    int base;
    reset = 1'b1;
    for (int i = 0; i < 3; i++)
      step(i[0] ? 1'b0 : 1'b1);
    chk("rst_data", {7'd0, pg.data_out}, 8'd0);
    chk("rst_busy", {7'd0, pg.busy}, 8'd0);
    chk("rst_drop", {7'd0, pg.dropped}, 8'd0);
    chk("rst_pend", {5'd0, pg.pend_count}, 8'd0);
    base  = rise_n;
    reset = 1'b0;
    idle(3);
    chk("rst_no_edge", 8'(rise_n - base), 8'd0);
  endtask

  task automatic test_single();
    int base;
    base = rise_n;
    step(1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step(1'b0);
      chk($sformatf("single_data_E%0d", k),
          {7'd0, pg.data_out},
          (k <= 3) ? 8'd1 : 8'd0);
      chk($sformatf("single_busy_E%0d", k),
          {7'd0, pg.busy},
          (k <= 5) ? 8'd1 : 8'd0);
    end
    chk("single_drop", {7'd0, pg.dropped}, 8'd0);
    idle(2);
    chk("single_edges", 8'(rise_n - base), 8'd1);
  endtask

  task automatic test_reset_mid_pulse();
    int base;
    base = rise_n;
    step(1'b1);
    step(1'b0);
    reset = 1'b1;
    step(1'b0);
    chk("mid_data", {7'd0, pg.data_out}, 8'd0);
    chk("mid_busy", {7'd0, pg.busy}, 8'd0);
    chk("mid_pend", {5'd0, pg.pend_count}, 8'd0);
    chk("mid_drop", {7'd0, pg.dropped}, 8'd0);
    reset = 1'b0;
    idle(8);
    chk("mid_data_end", {7'd0, pg.data_out}, 8'd0);
    chk("mid_edges", 8'(rise_n - base), 8'd1);
  endtask

`ifdef EDGE_PULSE_QUEUE_EN
  task automatic test_queue_pair();
    int base;
    logic [13:0] tr;
    base = rise_n;
    tr = 14'b00_0000_0000_0101;
    for (int k = 0; k < 14; k++) begin
      step(tr[k]);
      chk($sformatf("pair_data_E%0d", k),
          {7'd0, pg.data_out},
          (k <= 3 || (k >= 6 && k <= 9))
            ? 8'd1 : 8'd0);
      chk($sformatf("pair_busy_E%0d", k),
          {7'd0, pg.busy},
          (k <= 11) ? 8'd1 : 8'd0);
      if (k == 2 || k == 5)
        chk($sformatf("pair_pend_E%0d", k),
            {5'd0, pg.pend_count}, 8'd1);
      if (k == 6)
        chk("pair_pend_E6",
            {5'd0, pg.pend_count}, 8'd0);
    end
    chk("pair_drop", {7'd0, pg.dropped}, 8'd0);
    idle(2);
    chk("pair_edges", 8'(rise_n - base), 8'd2);
  endtask

  task automatic test_saturate();
    int base;
    base = rise_n;
    for (int k = 0; k < 10; k++) begin
      step(1'b1);
      if (k == 8) begin
        chk("sat_pend_E8",
            {5'd0, pg.pend_count}, 8'd7);
        chk("sat_drop_E8",
            {7'd0, pg.dropped}, 8'd0);
      end
    end
    chk("sat_pend_E9", {5'd0, pg.pend_count}, 8'd7);
    chk("sat_drop_E9", {7'd0, pg.dropped}, 8'd1);
    idle(60);
    chk("sat_edges", 8'(rise_n - base), 8'd9);
    for (int i = 1; i < 9; i++)
      chk($sformatf("sat_gap_%0d", i),
          8'(rise_cyc[base + i] -
             rise_cyc[base + i - 1]),
          8'd6);
    chk("sat_pend_end", {5'd0, pg.pend_count}, 8'd0);
    chk("sat_busy_end", {7'd0, pg.busy}, 8'd0);
  endtask
`else
  task automatic test_back_to_back();
    int base;
    logic [13:0] tr;
    base = rise_n;
    tr = 14'b00_0000_0100_1001;
    for (int k = 0; k < 14; k++) begin
      step(tr[k]);
      if (k == 2)
        chk("b2b_drop_E2",
            {7'd0, pg.dropped}, 8'd0);
      if (k == 3)
        chk("b2b_drop_E3",
            {7'd0, pg.dropped}, 8'd1);
      if (k == 4)
        chk("b2b_data_E4",
            {7'd0, pg.data_out}, 8'd0);
      if (k == 6)
        chk("b2b_data_E6",
            {7'd0, pg.data_out}, 8'd1);
      if (k == 12)
        chk("b2b_busy_E12",
            {7'd0, pg.busy}, 8'd0);
      chk($sformatf("b2b_pend_E%0d", k),
          {5'd0, pg.pend_count}, 8'd0);
    end
    idle(2);
    chk("b2b_edges", 8'(rise_n - base), 8'd2);
  endtask
`endif

  initial begin
    pg.trigger = 1'b0;
    test_reset();
    test_single();
    test_reset_mid_pulse();
`ifdef EDGE_PULSE_QUEUE_EN
    test_queue_pair();
    test_saturate();
`else
    test_back_to_back();
`endif
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
